// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/exception controller: stall, bubble, flush and next-PC select for a 5-stage pipe.
// Outputs are combinational (0-cycle) from state, mult/div counter and inputs; no internal buffering.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wait,
    input  logic       d_wait,
    input  logic       ld_use_D,
    input  logic       md_use_D,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic       exc_M,
    input  logic       eret_M,
    output logic       en_pc,
    output logic       en_fd,
    output logic       en_de,
    output logic       en_em,
    output logic       en_mw,
    output logic       flush_fd,
    output logic       flush_de,
    output logic       flush_em,
    output logic       flush_mw,
    output logic [1:0] pc_sel,
    output logic       md_busy
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_EXC   = 2'b01;
    localparam logic [1:0] PC_EPC   = 2'b10;
    localparam logic [5:0] MULT_CYC = 6'd5;
    localparam logic [5:0] DIV_CYC  = 6'd32;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_exc_sel;
    logic [1:0] w_exc_sel_nxt;
    logic [5:0] r_md_cnt;
    logic [5:0] w_md_cnt_nxt;

    logic       w_busy;
    logic       w_evt;
    logic       w_bubble;
    logic       w_en_pc;
    logic       w_en_fd;
    logic       w_en_de;
    logic       w_en_em;
    logic       w_en_mw;
    logic       w_flush_fd;
    logic       w_flush_de;
    logic       w_flush_em;
    logic       w_flush_mw;
    logic [1:0] w_pc_sel;

    assign w_busy   = (r_md_cnt != 6'd0);
    assign w_evt    = exc_M | eret_M;
    assign w_bubble = i_wait | (md_use_D & (w_busy | md_start_E)) | ld_use_D;

    // r_exc_sel is part of the FSM state: the vector chosen on entry to EXC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_exc_sel <= PC_SEQ;
            r_md_cnt  <= 6'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_exc_sel <= w_exc_sel_nxt;
            r_md_cnt  <= w_md_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_exc_sel_nxt = r_exc_sel;
        w_en_pc       = 1'b0;
        w_en_fd       = 1'b0;
        w_en_de       = 1'b0;
        w_en_em       = 1'b0;
        w_en_mw       = 1'b0;
        w_flush_fd    = 1'b0;
        w_flush_de    = 1'b0;
        w_flush_em    = 1'b0;
        w_flush_mw    = 1'b0;
        w_pc_sel      = PC_SEQ;
        case (r_state)
            ST_RUN: begin
                if (w_evt) begin
                    w_en_pc       = 1'b1;
                    w_flush_fd    = 1'b1;
                    w_flush_de    = 1'b1;
                    w_flush_em    = 1'b1;
                    w_flush_mw    = 1'b1;
                    w_pc_sel      = exc_M ? PC_EXC : PC_EPC;
                    w_exc_sel_nxt = exc_M ? PC_EXC : PC_EPC;
                    w_state_nxt   = ST_EXC;
                end else if (d_wait) begin
                    w_en_pc = 1'b0;
                end else if (w_bubble) begin
                    w_en_em    = 1'b1;
                    w_en_mw    = 1'b1;
                    w_flush_de = 1'b1;
                end else begin
                    w_en_pc = 1'b1;
                    w_en_fd = 1'b1;
                    w_en_de = 1'b1;
                    w_en_em = 1'b1;
                    w_en_mw = 1'b1;
                end
            end
            ST_EXC: begin
                // Keep flushing until the vector fetch is accepted by the I-SRAM.
                w_en_pc    = 1'b1;
                w_flush_fd = 1'b1;
                w_flush_de = 1'b1;
                w_flush_em = 1'b1;
                w_flush_mw = 1'b1;
                w_pc_sel   = r_exc_sel;
                if (!i_wait) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // A start is only taken when E actually advances and the unit is idle.
    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        if ((r_state == ST_RUN) && w_evt) begin
            w_md_cnt_nxt = 6'd0;
        end else if (md_start_E && w_en_em && !w_busy) begin
            w_md_cnt_nxt = md_div_E ? DIV_CYC : MULT_CYC;
        end else if (w_busy) begin
            w_md_cnt_nxt = r_md_cnt - 6'd1;
        end
    end

    assign en_pc    = rst & w_en_pc;
    assign en_fd    = rst & w_en_fd;
    assign en_de    = rst & w_en_de;
    assign en_em    = rst & w_en_em;
    assign en_mw    = rst & w_en_mw;
    assign flush_fd = rst & w_flush_fd;
    assign flush_de = rst & w_flush_de;
    assign flush_em = rst & w_flush_em;
    assign flush_mw = rst & w_flush_mw;
    assign pc_sel   = rst ? w_pc_sel : PC_SEQ;
    assign md_busy  = rst & w_busy;

endmodule
